// File: rtl/apb_slv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_slv_pkg : shared types and constants for the APB register-file completer.
// Revision    : 1.0
// ----------------------------------------------------------------------------
package apb_slv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } apb_slv_state_t;

   localparam logic [31:0] APB_SLV_ID    = 32'hA5B0_0001;
   localparam int          APB_SLV_CNT_W = 4;

   function automatic logic [31:0] apb_slv_strb_mask(input logic [3:0] strb);
      logic [31:0] mask;
      for (int k = 0; k < 4; k++) begin
         mask[8*k +: 8] = {8{strb[k]}};
      end
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slv_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_slv_regs : register array, address decode, error and byte-lane write.
// Macro APB_SLV_STRB_EN adds the read-with-strobe error. Revision: 1.0
// ----------------------------------------------------------------------------
module apb_slv_regs
   import apb_slv_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr_i,
   input  logic        write_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  strb_i,
   input  logic        commit_i,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int IDX_W = $clog2(NUM_REGS);

   logic [29:0]      w_word;
   logic [IDX_W-1:0] w_sel;
   logic             w_misaligned;
   logic             w_oob;
   logic             w_ro_write;
   logic             w_strb_rd_err;
   logic             w_err;
   logic             w_wr_en;
   logic [31:0]      w_mask;
   logic [31:0]      regs_q [1:NUM_REGS-1];
   logic [31:0]      regs_d [1:NUM_REGS-1];

   // Full 30-bit index is compared so aliases above the array are rejected.
   assign w_word       = addr_i[31:2];
   assign w_sel        = addr_i[IDX_W+1:2];
   assign w_misaligned = |addr_i[1:0];
   assign w_oob        = (w_word >= 30'(NUM_REGS));
   assign w_ro_write   = write_i && (w_word == '0);

`ifdef APB_SLV_STRB_EN
   assign w_strb_rd_err = !write_i && (|strb_i);
`else
   assign w_strb_rd_err = 1'b0;
`endif

   assign w_err   = w_misaligned || w_oob || w_ro_write || w_strb_rd_err;
   assign err_o   = w_err;
   assign w_mask  = apb_slv_strb_mask(strb_i);
   assign w_wr_en = commit_i && write_i && !w_err;

   always_comb begin
      for (int k = 1; k < NUM_REGS; k++) begin
         regs_d[k] = (regs_q[k] & ~w_mask) | (wdata_i & w_mask);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 1; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         for (int k = 1; k < NUM_REGS; k++) begin
            if (w_wr_en && (w_sel == IDX_W'(k))) begin
               regs_q[k] <= regs_d[k];
            end
         end
      end
   end

   always_comb begin
      rdata_o = APB_SLV_ID;
      for (int k = 1; k < NUM_REGS; k++) begin
         if (w_sel == IDX_W'(k)) begin
            rdata_o = regs_q[k];
         end
      end
      if (w_err) begin
         rdata_o = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_slave_regfile : APB completer with fixed wait states over a small regfile.
// Macro APB_SLV_STRB_EN adds pstrb_i byte-lane writes. Revision: 1.0
// ----------------------------------------------------------------------------
module apb_slave_regfile
   import apb_slv_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        psel_i,
   input  logic        penable_i,
   input  logic [31:0] paddr_i,
   input  logic        pwrite_i,
   input  logic [31:0] pwdata_i,
`ifdef APB_SLV_STRB_EN
   input  logic [3:0]  pstrb_i,
`endif
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o
);

   localparam logic [APB_SLV_CNT_W-1:0] WAIT_INIT = APB_SLV_CNT_W'(WAIT_CYCLES);

   apb_slv_state_t           state_q, state_d;
   logic [APB_SLV_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]              addr_q, addr_d;
   logic [31:0]              wdata_q, wdata_d;
   logic                     write_q, write_d;
   logic [3:0]               strb_q, strb_d;
   logic [3:0]               w_strb_in;
   logic                     w_setup;
   logic                     w_resp;
   logic                     w_err;
   logic [31:0]              w_rdata;

`ifdef APB_SLV_STRB_EN
   assign w_strb_in = pstrb_i;
`else
   assign w_strb_in = 4'hF;
`endif

   assign w_setup = psel_i && !penable_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      strb_d  = strb_q;
      case (state_q)
         ST_IDLE: begin
            if (w_setup) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!psel_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - APB_SLV_CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = w_setup ? ST_ACCESS : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Any entry into ACCESS is a setup cycle: latch the whole request here.
      if ((state_d == ST_ACCESS) && (state_q != ST_ACCESS)) begin
         cnt_d   = WAIT_INIT;
         addr_d  = paddr_i;
         wdata_d = pwdata_i;
         write_d = pwrite_i;
         strb_d  = w_strb_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         strb_q  <= strb_d;
      end
   end

   apb_slv_regs #(
      .NUM_REGS (NUM_REGS)
   ) u_regs (
      .clk      (clk),
      .reset    (reset),
      .addr_i   (addr_q),
      .write_i  (write_q),
      .wdata_i  (wdata_q),
      .strb_i   (strb_q),
      .commit_i (w_resp),
      .rdata_o  (w_rdata),
      .err_o    (w_err)
   );

   assign w_resp    = (state_q == ST_RESP);
   assign pready_o  = w_resp;
   assign pslverr_o = w_resp && w_err;
   assign prdata_o  = (w_resp && !write_q) ? w_rdata : '0;

endmodule
`default_nettype wire
